// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C state, bus event and bit-counter definitions
package i2c_pkg;

  // Bits counted per byte phase (0..8)
  localparam int BIT_CNT_W = 4;

  // Levels on SDA during the ninth clock
  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  // Bus conditions reported by the pin filter
  typedef enum logic [1:0] {
    EV_NONE,
    EV_START,
    EV_STOP
  } bus_ev_e;

  // Target protocol states
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV,
    ST_DACK,
    ST_MAH,
    ST_AKH,
    ST_MAL,
    ST_AKL,
    ST_WR,
    ST_AKW,
    ST_RD,
    ST_MACK
  } state_e;

endpackage

// File: rtl/i2c_mem_target_if.sv
// rtl/i2c_mem_target_if.sv - open-drain SCL/SDA pin bundle for the EEPROM target
interface i2c_mem_target_if;
  logic scl_i;
  logic sda_i;
  logic sda_o;
  logic sda_oen_o;

  modport slave (
    input  scl_i,
    input  sda_i,
    output sda_o,
    output sda_oen_o
  );

  modport master (
    output scl_i,
    output sda_i,
    input  sda_o,
    input  sda_oen_o
  );
endinterface

// File: rtl/i2c_pin_filter.sv
// rtl/i2c_pin_filter.sv - SCL/SDA synchroniser, glitch filter and bus condition detector
module i2c_pin_filter
  import i2c_pkg::*;
#(
  parameter int FILT = 3
) (
  input  logic    PCLK,
  input  logic    PRESET,
  input  logic    scl_i,
  input  logic    sda_i,
  output logic    sda,
  output logic    scl_rise,
  output logic    scl_fall,
  output bus_ev_e bus_ev
);

  localparam int CW = $clog2(FILT + 1);

  // Bit 0 carries SCL, bit 1 carries SDA throughout
  logic [1:0]    sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0]    filt_q, filt_d, prev_q, prev_d;
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];

  // Accept a new level only after FILT consecutive disagreeing samples
  always_comb begin
    sync1_d = {sda_i, scl_i};
    sync2_d = sync1_q;
    prev_d  = filt_q;
    filt_d  = filt_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != filt_q[i]) begin
        if (cnt_q[i] == CW'(FILT - 1)) filt_d[i] = sync2_q[i];
        else                           cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Pipeline registers; an idle bus reads high
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      sync1_q <= '1;
      sync2_q <= '1;
      filt_q  <= '1;
      prev_q  <= '1;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      filt_q  <= filt_d;
      prev_q  <= prev_d;
      for (int i = 0; i < 2; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign sda      = filt_q[1];
  assign scl_rise = filt_q[0] & ~prev_q[0];
  assign scl_fall = ~filt_q[0] & prev_q[0];

  // SDA moving while SCL stays high is a START (falling) or STOP (rising)
  always_comb begin
    bus_ev = EV_NONE;
    if (filt_q[0] && prev_q[0]) begin
      if (prev_q[1] && !filt_q[1])      bus_ev = EV_START;
      else if (!prev_q[1] && filt_q[1]) bus_ev = EV_STOP;
    end
  end

endmodule

// File: rtl/i2c_mem_target.sv
// rtl/i2c_mem_target.sv - I2C target emulating a 24xx-style serial EEPROM
module i2c_mem_target
  import i2c_pkg::*;
#(
  parameter logic [3:0] DEV_ID       = 4'b1010,
  parameter int         ADDR_BYTES   = 2,
  parameter int         MEM_DEPTH    = 256,
  parameter int         PAGE_SIZE    = 32,
  parameter int         WRITE_CYCLES = 50000,
  parameter int         FILT         = 3
) (
  input  logic                PCLK,
  input  logic                PRESET,
  i2c_mem_target_if.slave     bus,
  input  logic [2:0]          a_pins,
  input  logic                wp,
  output logic                busy
);

  localparam int               PTR_W     = $clog2(MEM_DEPTH);
  localparam int               CNT_W     = $clog2(WRITE_CYCLES + 1);
  localparam logic [PTR_W-1:0] PAGE_MASK = PTR_W'(PAGE_SIZE - 1);

  logic    sda_f, scl_rise, scl_fall;
  bus_ev_e bus_ev;

  i2c_pin_filter #(.FILT(FILT)) u_filter (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .scl_i    (bus.scl_i),
    .sda_i    (bus.sda_i),
    .sda      (sda_f),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .bus_ev   (bus_ev)
  );

  state_e               state_q, state_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [7:0]           shift_q, shift_d, hi_q, hi_d, rd_byte;
  logic [6:0]           tx_q, tx_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic                 oen_q, oen_d, wrote_q, wrote_d, mem_we;
  logic [CNT_W-1:0]     busy_cnt_q, busy_cnt_d;
  logic [7:0]           mem_q [MEM_DEPTH];

  // Protocol sequencing: bits captured on SCL rise, SDA drive changed on SCL fall
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    hi_d       = hi_q;
    ptr_d      = ptr_q;
    oen_d      = oen_q;
    wrote_d    = wrote_q;
    mem_we     = 1'b0;
    rd_byte    = mem_q[ptr_q];
    busy_cnt_d = (busy_cnt_q != '0) ? busy_cnt_q - 1'b1 : busy_cnt_q;
    if (bus_ev == EV_START) begin
      state_d   = ST_DEV;
      bit_cnt_d = '0;
      oen_d     = 1'b1;
      wrote_d   = 1'b0;
    end else if (bus_ev == EV_STOP) begin
      // Only a completed, unprotected data byte commits a write cycle
      if ((state_q == ST_WR || state_q == ST_AKW) && wrote_q)
        busy_cnt_d = CNT_W'(WRITE_CYCLES);
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      oen_d     = 1'b1;
      wrote_d   = 1'b0;
    end else if (scl_rise) begin
      case (state_q)
        ST_DEV, ST_MAH, ST_MAL, ST_WR, ST_RD: begin
          shift_d   = {shift_q[6:0], sda_f};
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
        ST_MACK: shift_d = {shift_q[6:0], sda_f};
        default: ;
      endcase
    end else if (scl_fall) begin
      case (state_q)
        ST_DEV: if (bit_cnt_q == BIT_CNT_W'(8)) begin
          if (shift_q[7:1] == {DEV_ID, a_pins} && busy_cnt_q == '0) begin
            state_d = ST_DACK;
            oen_d   = I2C_ACK;
          end else begin
            state_d = ST_IDLE;
            oen_d   = I2C_NACK;
          end
        end
        ST_DACK: begin
          bit_cnt_d = '0;
          if (shift_q[0]) begin
            state_d = ST_RD;
            tx_d    = rd_byte[6:0];
            oen_d   = rd_byte[7];
          end else begin
            hi_d    = '0;
            oen_d   = 1'b1;
            state_d = (ADDR_BYTES == 2) ? ST_MAH : ST_MAL;
          end
        end
        ST_MAH: if (bit_cnt_q == BIT_CNT_W'(8)) begin
          hi_d    = shift_q;
          state_d = ST_AKH;
          oen_d   = I2C_ACK;
        end
        ST_MAL: if (bit_cnt_q == BIT_CNT_W'(8)) begin
          ptr_d   = PTR_W'({hi_q, shift_q});
          state_d = ST_AKL;
          oen_d   = I2C_ACK;
        end
        ST_WR: if (bit_cnt_q == BIT_CNT_W'(8)) begin
          // Protected bytes are still ACKed, just not stored
          mem_we  = !wp;
          wrote_d = wrote_q | !wp;
          ptr_d   = (ptr_q & ~PAGE_MASK) | ((ptr_q + 1'b1) & PAGE_MASK);
          state_d = ST_AKW;
          oen_d   = I2C_ACK;
        end
        ST_AKH, ST_AKL, ST_AKW: begin
          state_d   = (state_q == ST_AKH) ? ST_MAL : ST_WR;
          bit_cnt_d = '0;
          oen_d     = 1'b1;
        end
        ST_RD: begin
          if (bit_cnt_q == BIT_CNT_W'(8)) begin
            state_d = ST_MACK;
            oen_d   = 1'b1;
            ptr_d   = ptr_q + 1'b1;
          end else begin
            oen_d = tx_q[6];
            tx_d  = {tx_q[5:0], 1'b0};
          end
        end
        ST_MACK: begin
          if (shift_q[0] == I2C_ACK) begin
            state_d   = ST_RD;
            bit_cnt_d = '0;
            tx_d      = rd_byte[6:0];
            oen_d     = rd_byte[7];
          end else begin
            state_d = ST_IDLE;
            oen_d   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Control state register
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= '0;
      hi_q       <= '0;
      ptr_q      <= '0;
      oen_q      <= 1'b1;
      wrote_q    <= 1'b0;
      busy_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      hi_q       <= hi_d;
      ptr_q      <= ptr_d;
      oen_q      <= oen_d;
      wrote_q    <= wrote_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  // Storage array keeps its contents across reset
  always_ff @(posedge PCLK) begin
    if (mem_we) mem_q[ptr_q] <= shift_q;
  end

  assign bus.sda_oen_o = oen_q;
  assign bus.sda_o     = oen_q;
  assign busy          = (busy_cnt_q != '0);

endmodule

// File: doc/i2c_mem_target.md
Name: i2c_mem_target

Overview:
- Synthesisable, parametrised I2C target that emulates a serial EEPROM (24xx family); the next generation of the behavioural EEPROM slave used on the APB2I2C benches.
- Configurable memory depth, 1- or 2-byte memory addressing, page size and strap-selected device address.
- Emulates the internal write cycle: NACKs while busy, so masters can ACK-poll.
- Sits on the open-drain SCL/SDA pins beside APB2I2C in system benches and FPGA loopback builds.

Parameters:
- DEV_ID, 4'b1010, upper 4 bits of the 7-bit device address.
- ADDR_BYTES, 2, memory-address bytes after the device address (1 or 2).
- MEM_DEPTH, 256, bytes of storage; power of two, 16..8192.
- PAGE_SIZE, 32, page-write wrap size; power of two, ≤ MEM_DEPTH.
- WRITE_CYCLES, 50000, PCLK cycles of busy time after a committed write (5 ms at 10 MHz).
- FILT, 3, consecutive equal samples required to accept an SCL/SDA level change.

Ports:
- PCLK  in  1  system clock
- PRESET  in  1  synchronous, active-high reset
- scl_i  in  1  SCL pin level
- sda_i  in  1  SDA pin level
- sda_o  out  1  SDA drive value; always 0 when driving
- sda_oen_o  out  1  0 = drive sda_o onto the pin; 1 = release
- a_pins  in  3  low 3 bits of the device address
- wp  in  1  write protect; 1 = ACK data bytes but discard them
- busy  out  1  internal write cycle in progress

Behaviour:
- Reset values: sda_o=1, sda_oen_o=1, busy=0, state IDLE, address pointer 0. Memory contents are not reset.
- Input conditioning: 2-FF synchroniser, then a FILT-sample glitch filter on each of SCL and SDA. Latency from pin to filtered level is 2+FILT cycles.
- START: filtered SDA falls while SCL is high. STOP: filtered SDA rises while SCL is high. Both are detected in any state.
- Timing: bits are sampled on the SCL rising edge. sda_oen_o/sda_o change only on the SCL falling edge, 1 cycle after detection.
- Device address: {DEV_ID, a_pins}. Match requires all 7 bits equal.
- States: IDLE, DEV, DACK, MAH, AKH, MAL, AKL, WR, AKW, RD, MACK.
  - IDLE: START → DEV.
  - DEV: 8 bits shifted MSB first.
    - Match and !busy → DACK (drive 0 for one SCL period).
    - Mismatch or busy → IDLE, bus released (NACK).
  - DACK, R/W=0: → MAH if ADDR_BYTES=2, else → MAL.
  - DACK, R/W=1: → RD, current pointer.
  - MAH → AKH → MAL → AKL → WR: pointer loaded as {hi,lo} mod MEM_DEPTH. Bits above log2(MEM_DEPTH) are ignored.
  - WR: after 8 bits, write the byte to mem[pointer] unless wp. Then AKH-style ACK (AKW) and pointer = {page base, (offset+1) mod PAGE_SIZE}. Page wrap; never crosses a page.
  - RD: drive mem[pointer] MSB first. Pointer increments mod MEM_DEPTH after the byte.
  - MACK: sample master ACK. ACK (0) → RD. NACK (1) → IDLE, released.
- Repeated START in any state → DEV; pointer kept (random read).
- STOP in WR/AKW after ≥1 data byte written (and !wp): load busy counter with WRITE_CYCLES and assert busy the next cycle. It decrements each cycle; busy=0 when it reaches 0.
- STOP after address bytes only: pointer updated, no busy.
- STOP or START mid-byte: the partial byte is discarded; SDA released within 1 cycle.
- busy=1 blocks only device-address ACK. The counter runs regardless of bus activity.
- PRESET mid-transfer: immediate return to reset values. A pending write cycle is abandoned; busy clears.
- sda_oen_o is never 0 while SCL is high except during ACK or read-data bits. No drive in IDLE.

Decomposition:
- Package i2c_pkg (shared with APB2I2C):
  - state enum
  - START/STOP/ACK/NACK constants
  - bit-counter width
- Sub-module i2c_pin_filter: synchroniser, glitch filter, edge/START/STOP detection. Instantiated once for SCL+SDA.

Test Plan:
- Address match: a_pins=3'b101, APB2I2C at 100 kHz sends 0x55 W → ACK on bit 9. Sending 0x54 W → NACK, sda_oen_o stays 1 throughout.
- Page write/read: write addr 0x0000 with data 10,20,30 then STOP → busy high for exactly 50000 PCLK. After busy falls, random read of 3 bytes from 0x0000 returns 10,20,30. The final master NACK releases the bus.
- ACK polling: send 0x55 W while busy=1 → NACK. Send it again after busy falls → ACK.
- Page wrap: PAGE_SIZE=32, write 4 bytes starting at 0x001E → bytes land at 0x1E,0x1F,0x00,0x01; 0x20 is unchanged.
- Write protect: wp=1, write 0xAA to 0x0005 → all bytes ACKed, busy stays 0, read-back returns the old value.
- Abort: STOP after 4 data bits, then PRESET pulsed mid-busy → no partial write; busy=0, sda_oen_o=1 the cycle after reset.
